// File: rtl/line_joltage_encoder.sv
// line_joltage_encoder: turns an ASCII digit stream into one word per line holding the
// largest two-digit number formed by an ordered digit pair, with a valid/ready output.
module line_joltage_encoder #(
    parameter logic [7:0] EOL_BYTE = 8'h0A,
    parameter int         CNT_W    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_value,
    output logic             out_short,
    input  logic             out_ready,
    output logic [CNT_W-1:0] line_count
);
    typedef enum logic [1:0] {EMPTY, ONE, MULTI} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_first_max;
    logic [6:0]  r_best;
    logic        w_acc, w_digit, w_eol, w_xfer, w_load, w_load_short;
    logic [3:0]  w_d;
    logic [6:0]  w_cand;
    logic [31:0] w_load_value;
    assign in_ready = !(out_valid && !out_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_digit  = in_byte >= 8'h30 && in_byte <= 8'h39;
    assign w_eol    = in_byte == EOL_BYTE && !w_digit;
    assign w_d      = in_byte[3:0];
    assign w_cand   = 7'(r_first_max) * 7'd10 + 7'(w_d);
    assign w_xfer   = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (w_acc && w_digit) ? (r_state == EMPTY ? ONE : MULTI) :
                 (w_acc && w_eol)   ? EMPTY : r_state;
    end
    always_comb begin
        w_load       = w_acc && w_eol && r_state != EMPTY;
        w_load_value = {25'd0, r_state == MULTI ? r_best : 7'd0};
        w_load_short = r_state == ONE;
    end
    // best must be updated from the old first_max before first_max itself moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_max <= '0;
            r_best      <= '0;
        end else if (w_acc && w_digit) begin
            r_first_max <= (r_state == EMPTY || w_d > r_first_max) ? w_d : r_first_max;
            r_best      <= (r_state == EMPTY) ? 7'd0 : (w_cand > r_best ? w_cand : r_best);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_short  <= 1'b0;
            line_count <= '0;
        end else begin
            out_valid  <= w_load || (out_valid && !out_ready);
            line_count <= line_count + CNT_W'(w_xfer);
            if (w_load) begin
                out_value <= w_load_value;
                out_short <= w_load_short;
            end
        end
    end
endmodule

// File: tb/tb_line_joltage_encoder.sv
// tb_line_joltage_encoder: scoreboard bench; a line-level reference model predicts each
// word when its EOL is accepted, and a monitor checks every word the DUT transfers out.
module tb_line_joltage_encoder;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, out_valid, out_short;
    logic [31:0] out_value;
    logic [8:0]  line_count;
    int          vectors = 0, miscompares = 0, word_sum = 0;
    bit          rand_ready = 1'b0;
    logic [32:0] exp_q[$];
    int          line_q[$];

    line_joltage_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .out_valid(out_valid), .out_value(out_value), .out_short(out_short),
        .out_ready(out_ready), .line_count(line_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: best ordered pair over all digits of the finished line
    function automatic void model_eol();
        int best = 0;
        if (line_q.size() == 0) return;
        if (line_q.size() == 1) exp_q.push_back({1'b1, 32'd0});
        else begin
            for (int i = 0; i < line_q.size(); i++)
                for (int j = i + 1; j < line_q.size(); j++)
                    if (10 * line_q[i] + line_q[j] > best) best = 10 * line_q[i] + line_q[j];
            exp_q.push_back({1'b0, 32'(best)});
        end
        line_q.delete();
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0d, want no word (t=%0t)", out_value, $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("word_value", out_value, e[31:0]);
                chk("word_short", {31'd0, out_short}, {31'd0, e[32]});
                word_sum += int'(out_value);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: byte %0d never accepted", b);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (b >= 8'h30 && b <= 8'h39) line_q.push_back(int'(b) - 48);
        else if (b == 8'h0A) model_eol();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_line_count", {23'd0, line_count}, 0);
        exp_q.delete();
        line_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", {31'd0, in_ready}, 1);
        word_sum = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            if (++n > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
                return;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_in_progress_valid", {31'd0, out_valid}, 0);
        do_reset();
        // single line, latency and count
        send_str("987654321111111\n");
        chk("lat1_valid", {31'd0, out_valid}, 1);
        chk("lat1_value", out_value, 98);
        chk("lat1_short", {31'd0, out_short}, 0);
        @(posedge clk);
        #1 chk("count_after_first", {23'd0, line_count}, 1);
        send_str("811111111111119\n234234234234278\n818181911112111\n");
        drain();
        chk("sum_four_lines", 32'(word_sum), 357);
        chk("count_four", {23'd0, line_count}, 4);
        // backpressure: word held, input stalled, then both words flow
        do_reset();
        out_ready = 1'b0;
        send_str("12\n");
        chk("held_valid", {31'd0, out_valid}, 1);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        fork
            send_str("34\n");
            begin
                repeat (3) @(negedge clk);
                chk("held_value", out_value, 12);
                chk("held_in_ready", {31'd0, in_ready}, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("count_two", {23'd0, line_count}, 2);
        // single-digit, blank and CR handling
        do_reset();
        send_str("5\n");
        chk("short_value", out_value, 0);
        chk("short_flag", {31'd0, out_short}, 1);
        send_str("\n7\r9\n");
        drain();
        chk("count_no_blank", {23'd0, line_count}, 2);
        // reset with a pending word, then with a partial line
        do_reset();
        send_str("99\n");
        out_ready = 1'b0;
        #3 chk("pending_before_rst", {31'd0, out_valid}, 1);
        #1 rst = 1'b1;
        #1 chk("async_drop", {31'd0, out_valid}, 0);
        exp_q.delete();
        line_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        send_str("99");
        do_reset();
        send_str("13\n");
        chk("post_rst_value", out_value, 13);
        drain();
        chk("post_rst_count", {23'd0, line_count}, 1);
        // back-to-back lines: transfer overlaps accumulation of the next line
        do_reset();
        send_str("12\n3\n45\n6\n");
        drain();
        chk("b2b_count", {23'd0, line_count}, 4);
        // randomized lines with random consumer stalls
        do_reset();
        rand_ready = 1'b1;
        for (int l = 0; l < 60; l++) begin
            int len = $urandom_range(0, 18);
            for (int k = 0; k < len; k++) begin
                int r = $urandom_range(0, 9);
                send_byte(r < 8 ? 8'(8'h30 + $urandom_range(0, 9)) : (r == 8 ? 8'h0D : 8'h41));
            end
            send_byte(8'h0A);
            in_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        rand_ready = 1'b0;
        #2 out_ready = 1'b1;
        drain();
        chk("rand_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
